// File: rtl/mem_stage_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: FSM states,
// alignment mask, bus widths and the MEM/WB register layout.
package mem_stage_access_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    // Word accesses only: any set bit under this mask means misaligned.
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] read_data;
    } mem_wb_t;

    function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
        return (addr[1:0] & MISALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_stage_access_ctrl_mem_wb_reg.sv
// MEM/WB pipeline register. A load captures a full new entry; a bubble
// only clears the write-back enable so the remaining fields hold.
module mem_wb_reg
    import mem_stage_access_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    bubble,
    input  mem_wb_t wb_in,
    output mem_wb_t wb_out
);

    mem_wb_t wb_q;
    mem_wb_t wb_d;

    // Next entry: new capture wins over bubble; otherwise hold.
    always_comb begin
        wb_d = wb_q;
        if (load) begin
            wb_d = wb_in;
        end else if (bubble) begin
            wb_d.reg_write = 1'b0;
        end
    end

    // Register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_out = wb_q;

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// MEM stage of the 5-stage core: issues EX/MEM loads/stores on a
// valid/ready data bus, stalls the front of the pipe until the access
// completes or times out, resolves the branch and feeds MEM/WB.
module mem_stage_access_ctrl
    import mem_stage_access_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        RD_MEM,
    input  logic              RegWrite_MEM,
    input  logic              MemtoReg_MEM,
    input  logic              MemRead_MEM,
    input  logic              MemWrite_MEM,
    input  logic              Branch_MEM,
    input  logic              Zero_MEM,
    input  logic [31:0]       ALU_OUT_MEM,
    input  logic [31:0]       PC_Branch_MEM,
    input  logic [31:0]       REG_DATA2_MEM_FINAL,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_resp_valid,
    input  logic [31:0]       dmem_rdata,
    output logic              Stall_MEM,
    output logic              PCSrc,
    output logic [31:0]       PC_Branch_OUT,
    output logic [4:0]        RD_WB,
    output logic              RegWrite_WB,
    output logic              MemtoReg_WB,
    output logic [31:0]       ALU_OUT_WB,
    output logic [31:0]       READ_DATA_WB,
    output logic              misalign_err,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic    access;
    logic    is_store;
    logic    misaligned;
    logic    at_limit;
    logic    req_valid;
    logic    stall;
    logic    mis_err;
    logic    to_err;
    logic    wb_load;
    logic    wb_bubble;
    logic    take_rdata;
    mem_wb_t wb_capture;
    mem_wb_t wb_q;

    assign access     = MemRead_MEM | MemWrite_MEM;
    assign is_store   = MemWrite_MEM;
    assign misaligned = access & is_misaligned(ALU_OUT_MEM);
    assign at_limit   = (wait_cnt_q == CNT_LIMIT);

    // Access sequencing: decide request, stall, MEM/WB action and next state.
    always_comb begin
        state_d    = state_q;
        req_valid  = 1'b0;
        stall      = 1'b0;
        mis_err    = 1'b0;
        to_err     = 1'b0;
        wb_load    = 1'b0;
        wb_bubble  = 1'b0;
        take_rdata = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!access) begin
                    wb_load = 1'b1;
                end else if (misaligned) begin
                    mis_err = 1'b1;
                    wb_load = 1'b1;
                end else begin
                    req_valid = 1'b1;
                    if (is_store && dmem_req_ready) begin
                        wb_load = 1'b1;
                    end else if (at_limit) begin
                        // Abort wins over a load handshake in the same
                        // cycle; its eventual response is ignored in IDLE.
                        to_err    = 1'b1;
                        wb_bubble = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        wb_bubble = 1'b1;
                        if (!is_store && dmem_req_ready) begin
                            state_d = ST_RESP;
                        end
                    end
                end
            end
            ST_RESP: begin
                if (dmem_resp_valid) begin
                    wb_load    = 1'b1;
                    take_rdata = 1'b1;
                    state_d    = ST_IDLE;
                end else if (at_limit) begin
                    to_err    = 1'b1;
                    wb_bubble = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Wait counter: counts stalled cycles, saturates, clears otherwise.
    always_comb begin
        wait_cnt_d = '0;
        if (stall) begin
            wait_cnt_d = at_limit ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Entry presented to MEM/WB; write-back suppressed for misaligned access.
    always_comb begin
        wb_capture.rd         = RD_MEM;
        wb_capture.reg_write  = RegWrite_MEM & ~misaligned;
        wb_capture.mem_to_reg = MemtoReg_MEM;
        wb_capture.alu_out    = ALU_OUT_MEM;
        wb_capture.read_data  = take_rdata ? dmem_rdata : wb_q.read_data;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst    (reset),
        .load   (wb_load),
        .bubble (wb_bubble),
        .wb_in  (wb_capture),
        .wb_out (wb_q)
    );

    // Everything combinational is forced quiet while reset is held, so a
    // request in flight disappears the moment reset rises.
    assign dmem_req_valid = req_valid & ~reset;
    assign dmem_we        = is_store & ~reset;
    assign dmem_addr      = reset ? '0 : ALU_OUT_MEM[ADDR_W-1:0];
    assign dmem_wdata     = reset ? '0 : REG_DATA2_MEM_FINAL;
    assign Stall_MEM      = stall & ~reset;
    assign misalign_err   = mis_err & ~reset;
    assign timeout_err    = to_err & ~reset;
    assign PCSrc          = Branch_MEM & Zero_MEM & ~stall & ~reset;
    assign PC_Branch_OUT  = reset ? '0 : PC_Branch_MEM;

    assign RD_WB        = wb_q.rd;
    assign RegWrite_WB  = wb_q.reg_write;
    assign MemtoReg_WB  = wb_q.mem_to_reg;
    assign ALU_OUT_WB   = wb_q.alu_out;
    assign READ_DATA_WB = wb_q.read_data;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Bench for mem_stage_access_ctrl: directed scenarios plus random traffic,
// every cycle checked against an access-level reference model.
module tb_mem_stage_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  RD_MEM = '0;
    logic        RegWrite_MEM = 1'b0, MemtoReg_MEM = 1'b0;
    logic        MemRead_MEM = 1'b0, MemWrite_MEM = 1'b0;
    logic        Branch_MEM = 1'b0, Zero_MEM = 1'b0;
    logic [31:0] ALU_OUT_MEM = '0, PC_Branch_MEM = '0, REG_DATA2_MEM_FINAL = '0;
    logic        dmem_req_ready = 1'b0, dmem_resp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    logic        dmem_req_valid, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        Stall_MEM, PCSrc;
    logic [31:0] PC_Branch_OUT;
    logic [4:0]  RD_WB;
    logic        RegWrite_WB, MemtoReg_WB;
    logic [31:0] ALU_OUT_WB, READ_DATA_WB;
    logic        misalign_err, timeout_err;

    always #5 clk = ~clk;

    mem_stage_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .RD_MEM(RD_MEM), .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .Branch_MEM(Branch_MEM), .Zero_MEM(Zero_MEM),
        .ALU_OUT_MEM(ALU_OUT_MEM), .PC_Branch_MEM(PC_Branch_MEM),
        .REG_DATA2_MEM_FINAL(REG_DATA2_MEM_FINAL),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
        .Stall_MEM(Stall_MEM), .PCSrc(PCSrc), .PC_Branch_OUT(PC_Branch_OUT),
        .RD_WB(RD_WB), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
        .ALU_OUT_WB(ALU_OUT_WB), .READ_DATA_WB(READ_DATA_WB),
        .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: whether a load has been accepted and awaits data,
    // how many cycles the current access has held the pipe, and MEM/WB.
    bit          m_busy;
    int          m_waits;
    logic [4:0]  m_rd;
    logic        m_rw, m_mtr;
    logic [31:0] m_alu, m_rdata;

    bit e_req, e_stall, e_mis, e_to, e_pc;
    logic s_req, s_stall, s_mis, s_to, s_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waits = 0;
        m_rd = '0; m_rw = 1'b0; m_mtr = 1'b0; m_alu = '0; m_rdata = '0;
        e_stall = 0;
    endtask

    task automatic set_instr(input logic [4:0] rd, input logic rw, input logic mtr,
                             input logic mr, input logic mw, input logic br, input logic z,
                             input logic [31:0] alu, input logic [31:0] pcb, input logic [31:0] wd);
        RD_MEM = rd; RegWrite_MEM = rw; MemtoReg_MEM = mtr;
        MemRead_MEM = mr; MemWrite_MEM = mw; Branch_MEM = br; Zero_MEM = z;
        ALU_OUT_MEM = alu; PC_Branch_MEM = pcb; REG_DATA2_MEM_FINAL = wd;
    endtask

    task automatic set_mem(input logic rdy, input logic rv, input logic [31:0] rd);
        dmem_req_ready = rdy; dmem_resp_valid = rv; dmem_rdata = rd;
    endtask

    // One clock: predict and compare at the falling edge, advance the model
    // at the rising edge, return just after it so new inputs can be applied.
    task automatic tick();
        bit acc, st, mis, finish, got_data;
        @(negedge clk);
        acc = MemRead_MEM || MemWrite_MEM;
        st  = MemWrite_MEM;
        mis = acc && (ALU_OUT_MEM % 4 != 0);
        e_req = 0; e_stall = 0; e_mis = 0; e_to = 0; finish = 0; got_data = 0;
        if (m_busy) begin
            if (dmem_resp_valid) begin finish = 1; got_data = 1; end
            else if (m_waits == TO) e_to = 1;
            else e_stall = 1;
        end else if (!acc) begin
            finish = 1;
        end else if (mis) begin
            e_mis = 1; finish = 1;
        end else begin
            e_req = 1;
            if (st && dmem_req_ready) finish = 1;
            else if (m_waits == TO) e_to = 1;
            else e_stall = 1;
        end
        e_pc = Branch_MEM && Zero_MEM && !e_stall;

        s_req = dmem_req_valid; s_stall = Stall_MEM; s_mis = misalign_err;
        s_to = timeout_err; s_ready = dmem_req_ready;

        check("req_valid", {31'd0, dmem_req_valid}, {31'd0, e_req});
        check("stall", {31'd0, Stall_MEM}, {31'd0, e_stall});
        check("misalign_err", {31'd0, misalign_err}, {31'd0, e_mis});
        check("timeout_err", {31'd0, timeout_err}, {31'd0, e_to});
        check("pcsrc", {31'd0, PCSrc}, {31'd0, e_pc});
        if (!e_stall) check("pc_branch_out", PC_Branch_OUT, PC_Branch_MEM);
        if (e_req) begin
            check("dmem_we", {31'd0, dmem_we}, {31'd0, st});
            check("dmem_addr", dmem_addr, ALU_OUT_MEM);
            check("dmem_wdata", dmem_wdata, REG_DATA2_MEM_FINAL);
        end
        check("rd_wb", {27'd0, RD_WB}, {27'd0, m_rd});
        check("regwrite_wb", {31'd0, RegWrite_WB}, {31'd0, m_rw});
        check("memtoreg_wb", {31'd0, MemtoReg_WB}, {31'd0, m_mtr});
        check("alu_out_wb", ALU_OUT_WB, m_alu);
        check("read_data_wb", READ_DATA_WB, m_rdata);

        if (finish || e_to)
            $display("txn t=%0t rd=%0d rd_en=%0b wr_en=%0b addr=%h waited=%0d %s",
                     $time, RD_MEM, MemRead_MEM, MemWrite_MEM, ALU_OUT_MEM, m_waits,
                     e_to ? "timeout" : (e_mis ? "misaligned" : "done"));

        @(posedge clk);
        if (finish) begin
            m_rd = RD_MEM; m_rw = RegWrite_MEM && !e_mis; m_mtr = MemtoReg_MEM;
            m_alu = ALU_OUT_MEM;
            if (got_data) m_rdata = dmem_rdata;
        end else begin
            m_rw = 1'b0;
        end
        if (finish || e_to) m_busy = 0;
        else if (!m_busy && e_req && !st && dmem_req_ready) m_busy = 1;
        m_waits = e_stall ? m_waits + 1 : 0;
        #1;
    endtask

    task automatic rand_instr();
        int kind;
        logic [31:0] addr;
        if (e_stall) return;
        kind = $urandom_range(0, 3);
        addr = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
        set_instr(5'($urandom), 1'($urandom), 1'($urandom),
                  kind == 1 || kind == 3, kind == 2 || kind == 3,
                  1'($urandom), 1'($urandom), addr, $urandom, $urandom);
    endtask

    initial begin
        int stalls, bubbles, hs, to_at;
        model_reset();

        // Reset state, with an aligned load and a taken branch presented.
        #2;
        set_instr(5'd1, 1, 1, 1, 0, 1, 1, 32'h100, 32'h40, 32'h0);
        set_mem(1, 1, 32'h1);
        #1;
        check("rst_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("rst_stall", {31'd0, Stall_MEM}, 32'd0);
        check("rst_pcsrc", {31'd0, PCSrc}, 32'd0);
        check("rst_rd_wb", {27'd0, RD_WB}, 32'd0);
        check("rst_read_data_wb", READ_DATA_WB, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        set_mem(0, 0, 0);

        // 1: ALU op, one-cycle capture.
        set_instr(5'd5, 1, 0, 0, 0, 0, 0, 32'h10, 32'h0, 32'h0);
        tick();
        check("t1_rd_wb", {27'd0, RD_WB}, 32'd5);
        check("t1_alu_out_wb", ALU_OUT_WB, 32'h10);
        check("t1_regwrite_wb", {31'd0, RegWrite_WB}, 32'd1);

        // 2: load accepted at once, data three cycles later.
        stalls = 0; bubbles = 0;
        set_instr(5'd7, 1, 1, 1, 0, 0, 0, 32'h100, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) set_mem(1, 0, 0);
            else if (i == 3) set_mem(0, 1, 32'hCAFE);
            else set_mem(0, 0, 0);
            tick();
            stalls += int'(s_stall);
            if (i < 3 && RegWrite_WB == 1'b0) bubbles++;
        end
        check("t2_stall_cycles", stalls, 32'd3);
        check("t2_bubbles", bubbles, 32'd3);
        check("t2_read_data_wb", READ_DATA_WB, 32'hCAFE);
        check("t2_rd_wb", {27'd0, RD_WB}, 32'd7);

        // 3: store held off by ready for two cycles.
        stalls = 0; hs = 0;
        set_instr(5'd3, 0, 0, 0, 1, 0, 0, 32'h200, 32'h0, 32'h55);
        for (int i = 0; i < 3; i++) begin
            set_mem(i == 2, 0, 0);
            tick();
            stalls += int'(s_stall);
            if (s_req && s_ready) hs++;
        end
        check("t3_stall_cycles", stalls, 32'd2);
        check("t3_handshakes", hs, 32'd1);

        // 4: misaligned load.
        set_instr(5'd9, 1, 1, 1, 0, 0, 0, 32'h102, 32'h0, 32'h0);
        set_mem(1, 0, 0);
        tick();
        check("t4_misalign_err", {31'd0, s_mis}, 32'd1);
        check("t4_req_valid", {31'd0, s_req}, 32'd0);
        check("t4_stall", {31'd0, s_stall}, 32'd0);
        check("t4_regwrite_wb", {31'd0, RegWrite_WB}, 32'd0);

        // 5: accepted load never answered, then a stray response.
        set_instr(5'd4, 1, 1, 1, 0, 0, 0, 32'h300, 32'h0, 32'h0);
        set_mem(1, 0, 0);
        tick();
        set_mem(0, 0, 0);
        to_at = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (s_to) begin to_at = i; break; end
        end
        check("t5_timeout_wait_cycle", to_at, 32'd4);
        check("t5_stall_at_timeout", {31'd0, s_stall}, 32'd0);
        set_instr(5'd6, 0, 0, 0, 0, 0, 0, 32'h44, 32'h0, 32'h0);
        set_mem(0, 1, 32'hDEAD);
        tick();
        check("t5_stray_ignored", READ_DATA_WB, 32'hCAFE);

        // 6: reset while waiting for load data.
        set_instr(5'd8, 1, 1, 1, 0, 1, 1, 32'h400, 32'h80, 32'h0);
        set_mem(1, 0, 0);
        tick();
        set_mem(0, 0, 0);
        tick();
        #2 reset = 1'b1;
        #1;
        check("t6_req_valid", {31'd0, dmem_req_valid}, 32'd0);
        check("t6_stall", {31'd0, Stall_MEM}, 32'd0);
        check("t6_pcsrc", {31'd0, PCSrc}, 32'd0);
        check("t6_regwrite_wb", {31'd0, RegWrite_WB}, 32'd0);
        check("t6_read_data_wb", READ_DATA_WB, 32'd0);
        check("t6_alu_out_wb", ALU_OUT_WB, 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        set_mem(1, 0, 0);
        tick();
        set_mem(0, 1, 32'hBEEF);
        tick();
        check("t6_reload_data", READ_DATA_WB, 32'hBEEF);
        check("t6_reload_rd", {27'd0, RD_WB}, 32'd8);

        // Random traffic: instructions held while the model expects a stall.
        for (int i = 0; i < 2000; i++) begin
            rand_instr();
            set_mem(($urandom % 3) != 0, ($urandom % 3) == 0, $urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
